// File: rtl/chord_game_ctrl.sv
// rtl/chord_game_ctrl.sv - timed chord-matching game core: sync, LFSR, blink clock, round FSM
module chord_game_ctrl #(
    parameter int          TICK_DIV     = 50000000,
    parameter int          BLINK_DIV    = 12500000,
    parameter int          GAME_SECONDS = 60,
    parameter logic [31:0] LFSR_SEED    = 32'hACE11234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic [11:0] sw,
    output logic [1:0]  state,
    output logic [11:0] chord,
    output logic [31:0] time_or_score,
    output logic [31:0] random,
    output logic        blinClock
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [13:0]   GAME_TIME  = 14'(GAME_SECONDS);
    localparam logic [13:0]   SCORE_MAX  = 14'd9999;
    localparam logic [31:0]   LFSR_POLY  = 32'h80200003;
    localparam logic [11:0]   CHORD_ALT  = 12'h249;

    state_t         state_q, state_d;
    logic [11:0]    chord_d;
    logic [13:0]    timer_q, timer_d;
    logic [13:0]    score_q, score_d;
    logic [31:0]    tos_d;
    logic [31:0]    lfsr_q;
    logic [TW-1:0]  tick_cnt;
    logic [BW-1:0]  blink_cnt;
    logic           btn_s1, btn_s2, btn_s3;
    logic [11:0]    sw_s1, sw_sync;
    logic           start_pulse, sec_tick, tick_clr, match;
    logic [11:0]    c0, cand;

    assign state       = state_q;
    assign random      = lfsr_q;
    assign start_pulse = btn_s2 & ~btn_s3;
    assign sec_tick    = (tick_cnt == TICK_LAST);
    assign match       = (sw_sync == chord);

    // Two-flop synchronizers plus one extra stage for start edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_s3  <= 1'b0;
            sw_s1   <= 12'd0;
            sw_sync <= 12'd0;
        end else begin
            btn_s1  <= start_btn;
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
            sw_s1   <= sw;
            sw_sync <= sw_s1;
        end
    end

    // Galois LFSR, x^32+x^22+x^2+x+1, free-running in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
        end
    end

    // Blink clock divider, toggles on each counter wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blinClock <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blinClock <= ~blinClock;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // One-second tick counter, realigned on round entry so the first tick is a full second away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_clr || sec_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Next chord: never zero and never equal to the chord currently shown
    always_comb begin
        c0 = (lfsr_q[11:0] == 12'd0) ? CHORD_ALT : lfsr_q[11:0];
        if (c0 != chord) begin
            cand = c0;
        end else if (chord == 12'hFFF) begin
            cand = CHORD_ALT;
        end else begin
            cand = {c0[10:0], c0[11]};
        end
    end

    // Round state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            chord         <= 12'd0;
            timer_q       <= 14'd0;
            score_q       <= 14'd0;
            time_or_score <= 32'd0;
        end else begin
            state_q       <= state_d;
            chord         <= chord_d;
            timer_q       <= timer_d;
            score_q       <= score_d;
            time_or_score <= tos_d;
        end
    end

    // Next-state and next-output decode; abort has priority over match and tick
    always_comb begin
        state_d  = state_q;
        chord_d  = chord;
        timer_d  = timer_q;
        score_d  = score_q;
        tick_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                chord_d = 12'd0;
                timer_d = 14'd0;
                score_d = 14'd0;
                if (start_pulse) begin
                    state_d  = S_PLAY;
                    chord_d  = cand;
                    timer_d  = GAME_TIME;
                    tick_clr = 1'b1;
                end
            end
            S_PLAY: begin
                if (start_pulse) begin
                    state_d = S_IDLE;
                    chord_d = 12'd0;
                    timer_d = 14'd0;
                    score_d = 14'd0;
                end else begin
                    if (match) begin
                        score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 14'd1;
                        chord_d = cand;
                    end
                    if (sec_tick) begin
                        if (timer_q <= 14'd1) begin
                            timer_d = 14'd0;
                            state_d = S_RESULT;
                            chord_d = 12'd0;
                        end else begin
                            timer_d = timer_q - 14'd1;
                        end
                    end
                end
            end
            S_RESULT: begin
                chord_d = 12'd0;
                timer_d = 14'd0;
                if (start_pulse) begin
                    state_d = S_IDLE;
                    score_d = 14'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                chord_d = 12'd0;
                timer_d = 14'd0;
                score_d = 14'd0;
            end
        endcase

        case (state_d)
            S_PLAY:   tos_d = {18'd0, timer_d};
            S_RESULT: tos_d = {18'd0, score_d};
            default:  tos_d = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_chord_game_ctrl.sv
// tb/tb_chord_game_ctrl.sv - self-checking bench for chord_game_ctrl
module tb_chord_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic [11:0] sw = 12'd0;
    logic [1:0]  state;
    logic [11:0] chord;
    logic [31:0] time_or_score, random;
    logic        blinClock;

    logic        start_b = 1'b0;
    logic [11:0] sw_b = 12'd0;
    logic [1:0]  state_b;
    logic [11:0] chord_b;
    logic [31:0] tos_b, random_b;
    logic        blin_b;

    chord_game_ctrl #(.TICK_DIV(10), .BLINK_DIV(4), .GAME_SECONDS(3), .LFSR_SEED(32'hACE11234)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .sw(sw),
        .state(state), .chord(chord), .time_or_score(time_or_score),
        .random(random), .blinClock(blinClock)
    );

    chord_game_ctrl #(.TICK_DIV(4), .BLINK_DIV(4), .GAME_SECONDS(9999), .LFSR_SEED(32'hACE11234)) u_sat (
        .clk(clk), .rst_n(rst_n), .start_btn(start_b), .sw(sw_b),
        .state(state_b), .chord(chord_b), .time_or_score(tos_b),
        .random(random_b), .blinClock(blin_b)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        btn;
        int          wait_cyc;
        logic [1:0]  st;
        logic [31:0] tos;
        logic        chord_nz;
    } vec_t;

    vec_t        vt[13];
    logic [32:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_btn = 1'b0;
        start_b = 1'b0;
        sw = 12'd0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        step(2);
    endtask

    function automatic logic [31:0] galois(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    initial begin
        logic [31:0] m_lfsr;
        logic [32:0] e;
        logic [11:0] old, cur;
        int          cyc, nochange;

        vt[0]  = '{1'b1, 1, 2'd0, 32'd0, 1'b0};
        vt[1]  = '{1'b0, 1, 2'd0, 32'd0, 1'b0};
        vt[2]  = '{1'b0, 1, 2'd1, 32'd3, 1'b1};
        vt[3]  = '{1'b0, 9, 2'd1, 32'd3, 1'b1};
        vt[4]  = '{1'b0, 1, 2'd1, 32'd2, 1'b1};
        vt[5]  = '{1'b0, 9, 2'd1, 32'd2, 1'b1};
        vt[6]  = '{1'b0, 1, 2'd1, 32'd1, 1'b1};
        vt[7]  = '{1'b0, 9, 2'd1, 32'd1, 1'b1};
        vt[8]  = '{1'b0, 1, 2'd2, 32'd0, 1'b0};
        vt[9]  = '{1'b0, 5, 2'd2, 32'd0, 1'b0};
        vt[10] = '{1'b1, 1, 2'd2, 32'd0, 1'b0};
        vt[11] = '{1'b0, 1, 2'd2, 32'd0, 1'b0};
        vt[12] = '{1'b0, 1, 2'd0, 32'd0, 1'b0};

        // reset values and idle-screen LFSR / blink sequence
        do_reset();
        m_lfsr = 32'hACE11234;
        check("rst_state", 32'(state), 32'd0);
        check("rst_chord", 32'(chord), 32'd0);
        check("rst_tos", time_or_score, 32'd0);
        check("rst_random", random, 32'hACE11234);
        check("rst_blink", 32'(blinClock), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            m_lfsr = galois(m_lfsr);
            sb_q.push_back({1'((i / 4) % 2), m_lfsr});
            step(1);
            e = sb_q.pop_front();
            check($sformatf("random_%0d", i), random, e[31:0]);
            check($sformatf("blink_%0d", i), 32'(blinClock), 32'(e[32]));
            if (i == 1) check("random_first", random, 32'h5670891A);
        end
        check("idle_state", 32'(state), 32'd0);
        check("idle_chord", 32'(chord), 32'd0);

        // single press, full round with no matches, result, back to idle
        do_reset();
        for (int i = 0; i < 13; i++) begin
            start_btn = vt[i].btn;
            step(vt[i].wait_cyc);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
            check($sformatf("vec%0d_tos", i), time_or_score, vt[i].tos);
            check($sformatf("vec%0d_chord_nz", i), 32'(chord != 12'd0), 32'(vt[i].chord_nz));
        end

        // held button gives a single entry and no abort
        do_reset();
        start_btn = 1'b1;
        step(20);
        check("hold_state_play", 32'(state), 32'd1);
        check("hold_tos", time_or_score, 32'd2);
        step(30);
        check("hold_state_result", 32'(state), 32'd2);
        start_btn = 1'b0;
        step(5);
        check("hold_release_state", 32'(state), 32'd2);

        // five matches, then stale switches must not score again
        do_reset();
        pulse_start();
        check("match_entry_state", 32'(state), 32'd1);
        for (int k = 0; k < 5; k++) begin
            old = chord;
            sw = chord;
            step(2);
            check($sformatf("match%0d_pre", k), 32'(chord), 32'(old));
            step(1);
            check($sformatf("match%0d_new", k), 32'(chord != old), 32'd1);
            check($sformatf("match%0d_nz", k), 32'(chord != 12'd0), 32'd1);
        end
        cur = chord;
        step(6);
        check("stale_sw_chord", 32'(chord), 32'(cur));
        cyc = 0;
        while (state != 2'd2 && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("match_result_state", 32'(state), 32'd2);
        check("match_score", time_or_score, 32'd5);
        check("match_result_chord", 32'(chord), 32'd0);

        // match on the final tick is counted
        do_reset();
        pulse_start();
        step(27);
        sw = chord;
        step(2);
        check("final_pre_state", 32'(state), 32'd1);
        check("final_pre_tos", time_or_score, 32'd1);
        step(1);
        check("final_state", 32'(state), 32'd2);
        check("final_score", time_or_score, 32'd1);
        check("final_chord", 32'(chord), 32'd0);

        // abort in play
        do_reset();
        pulse_start();
        sw = chord;
        step(3);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        step(1);
        check("abort_pre_state", 32'(state), 32'd1);
        step(1);
        check("abort_state", 32'(state), 32'd0);
        check("abort_tos", time_or_score, 32'd0);
        check("abort_chord", 32'(chord), 32'd0);

        // asynchronous reset in play
        do_reset();
        pulse_start();
        step(5);
        check("arst_pre_state", 32'(state), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_chord", 32'(chord), 32'd0);
        check("arst_tos", time_or_score, 32'd0);
        check("arst_random", random, 32'hACE11234);
        check("arst_blink", 32'(blinClock), 32'd0);
        #2;
        rst_n = 1'b1;
        step(1);

        // score saturation on the long-round instance
        do_reset();
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        step(2);
        check("sat_entry_state", 32'(state_b), 32'd1);
        nochange = 0;
        for (int k = 0; k < 10005; k++) begin
            old = chord_b;
            sw_b = chord_b;
            step(3);
            if (chord_b == old) nochange++;
        end
        check("sat_chord_changes", 32'(nochange), 32'd0);
        cyc = 0;
        while (state_b != 2'd2 && cyc < 20000) begin
            step(1);
            cyc++;
        end
        check("sat_result_state", 32'(state_b), 32'd2);
        check("sat_score", tos_b, 32'd9999);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
